uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and helpers for uart_tx (UART_TX_PARITY_EN adds the PARITY state)
package Definitions;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int CeilLog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-time counter emitting a tick on the last clk of each serial bit
module uart_baud_tick
    import Definitions::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = CeilLog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Count clks within a bit; wrap on the tick, park at zero when cleared or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional even parity (UART_TX_PARITY_EN), stop
module uart_tx
    import Definitions::*;
#(
    parameter int WORD_LENGHT  = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGHT-1:0] TX_data,
    input  logic                   TX_start,
    output logic                   TX_ready,
    output logic                   TX_out,
    output logic                   TX_done
);

    localparam int BIT_W = CeilLog2(WORD_LENGHT);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_LENGHT - 1);

    tx_state_t              state, state_next;
    logic [WORD_LENGHT-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_next;
    logic                   out_next;
    logic                   done_next;
    logic                   tick;

    assign TX_ready = (state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .clear  (state == IDLE),
        .tick   (tick)
    );

    // State, shift register, bit counter and the registered line/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            TX_out    <= 1'b1;
            TX_done   <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            TX_out    <= out_next;
            TX_done   <= done_next;
        end
    end

    // Next state plus the line level of the bit that state will present.
    // The word rotates rather than shifts, so its XOR (the parity) is unchanged
    // and a full pass through DATA leaves the original word in place.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        out_next     = TX_out;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                out_next = 1'b1;
                if (TX_start) begin
                    state_next = START;
                    shift_next = TX_data;
                    out_next   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    out_next   = shift_reg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = {shift_reg[0], shift_reg[WORD_LENGHT-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
                        out_next     = ^shift_reg;
`else
                        state_next   = STOP;
                        out_next     = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                        out_next     = shift_next[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    out_next   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    out_next   = 1'b1;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                out_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx (follows UART_TX_PARITY_EN)
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WL    = 8;
    localparam int FRAME = WL + 2 + PAR;

    typedef struct {
        logic out;
        logic done;
        logic ready;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WL-1:0] tx_data = '0;
    logic          tx_start = 1'b0;
    logic          tx_ready, tx_out, tx_done;
    logic [WL-1:0] d4 = '0;
    logic          s4 = 1'b0;
    logic          ready4, out4, done4;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    uart_tx #(.WORD_LENGHT(WL), .CLKS_PER_BIT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .TX_data  (tx_data),
        .TX_start (tx_start),
        .TX_ready (tx_ready),
        .TX_out   (tx_out),
        .TX_done  (tx_done)
    );

    uart_tx #(.WORD_LENGHT(WL), .CLKS_PER_BIT(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .TX_data  (d4),
        .TX_start (s4),
        .TX_ready (ready4),
        .TX_out   (out4),
        .TX_done  (done4)
    );

    function automatic logic frame_bit(input logic [WL-1:0] w, input int i);
        if (i == 0) return 1'b0;
        if (i <= WL) return w[i-1];
        if (PAR == 1 && i == WL + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [WL-1:0] w);
        exp_t e;
        for (int i = 0; i < FRAME; i++) begin
            e.out = frame_bit(w, i); e.done = 1'b0; e.ready = 1'b0;
            q.push_back(e);
        end
        e.out = 1'b1; e.done = 1'b1; e.ready = 1'b1;
        q.push_back(e);
    endtask

    task automatic push_idle();
        exp_t e;
        e.out = 1'b1; e.done = 1'b0; e.ready = 1'b1;
        q.push_back(e);
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                check("scoreboard_empty", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                check("tx_out", tx_out, e.out);
                check("tx_done", tx_done, e.done);
                check("tx_ready", tx_ready, e.ready);
            end
        end
    endtask

    task automatic drain_all();
        drain(q.size());
    endtask

    task automatic send(input logic [WL-1:0] w);
        @(negedge clk);
        check("ready_before_send", tx_ready, 1'b1);
        tx_data  = w;
        tx_start = 1'b1;
        push_frame(w);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_data  = ~w;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_out", tx_out, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_done", tx_done, 1'b0);
        check("rst_out4", out4, 1'b1);
        check("rst_ready4", ready4, 1'b1);
        check("rst_done4", done4, 1'b0);
        rst = 1'b0;

        // A5 and 07 frames
        send(8'hA5);
        drain_all();
        send(8'h07);
        drain_all();

        // start pulsed mid-frame is ignored
        send(8'h3C);
        drain(3);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        drain(1);
        tx_start = 1'b0;
        drain_all();
        push_idle();
        drain(1);

        // back-to-back frames with start held high
        @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        push_frame(8'h55);
        @(posedge clk);
        #1;
        drain(FRAME + 1);
        tx_data = 8'hAA;
        push_frame(8'hAA);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        drain_all();

        // reset during data bit 4 of F0
        send(8'hF0);
        drain(5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out", tx_out, 1'b1);
        check("midrst_ready", tx_ready, 1'b1);
        check("midrst_done", tx_done, 1'b0);
        q.delete();
        @(negedge clk);
        check("rst_hold_done", tx_done, 1'b0);
        @(negedge clk);
        check("rst_hold_done2", tx_done, 1'b0);
        rst      = 1'b0;
        tx_data  = 8'h07;
        tx_start = 1'b1;
        push_frame(8'h07);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        drain_all();

        // four clks per bit
        @(negedge clk);
        d4 = 8'h01;
        s4 = 1'b1;
        @(posedge clk);
        #1;
        s4 = 1'b0;
        d4 = 8'hFE;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            check("out4", out4, frame_bit(8'h01, i / 4));
            check("done4_busy", done4, 1'b0);
        end
        @(negedge clk);
        check("done4_end", done4, 1'b1);
        check("ready4_end", ready4, 1'b1);
        @(negedge clk);
        check("done4_after", done4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
